move_collector: RTL and testbench

Drains the 64 per-square move FIFOs after move generation and serialises every valid 19-bit move onto one ready/valid stream for the search and evaluation logic. Sits directly downstream of the 8×8 array of square units. It waits until all squares report done, then scans squares 0..63 in order. For each queued 160-bit FIFO word it emits the valid lanes and drops the invalid ones.

---
 rtl/chess_pkg.sv | 89 ++++++++
 rtl/move_lane_sel.sv | 29 ++
 rtl/move_collector.sv | 177 +++++++++++++++++
 tb/tb_move_collector.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared definitions for the move-generation fabric: piece codes, move
// layout and flag positions, collector geometry and the collector states.
package chess_pkg;

   // Board / collector geometry
   localparam int NSQ   = 64;           // square units / FIFOs
   localparam int LANES = 8;            // move lanes per FIFO word
   localparam int MVW   = 19;           // move width
   localparam int CNTW  = 8;            // move counter width
   localparam int WORDW = 160;          // FIFO word width
   localparam int PAYW  = LANES * MVW;  // lane payload, bits 151:0
   localparam int SQW   = 6;            // square index width
   localparam int KW    = 3;            // lane index width

   // Piece codes
   typedef enum logic [2:0] {
      EMPTY  = 3'd0,
      PAWN   = 3'd1,
      KNIGHT = 3'd2,
      BISHOP = 3'd3,
      ROOK   = 3'd4,
      QUEEN  = 3'd5,
      KING   = 3'd6
   } piece_t;

   typedef enum logic {
      WHITE = 1'b0,
      BLACK = 1'b1
   } color_t;

   typedef struct packed {
      color_t color;
      piece_t piece;
   } cpiece_t;

   // Move layout: [18:12] flags, [11:6] from, [5:0] to
   localparam int FLG_INVALID = 18;
   localparam int FLG_PROMOTE = 17;
   localparam int FLG_PAWN    = 16;
   localparam int FLG_PAWN2   = 15;
   localparam int FLG_EP      = 14;
   localparam int FLG_CASTLE  = 13;
   localparam int FLG_CAPTURE = 12;

   typedef struct packed {
      logic [6:0] flags;
      logic [5:0] from_sq;
      logic [5:0] to_sq;
   } move_t;

   // Filler for unused lanes: only the invalid flag set
   localparam logic [MVW-1:0] IMOV = 19'h40000;

   // Collector states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAITD = 3'd1,
      ST_SCAN  = 3'd2,
      ST_READ  = 3'd3,
      ST_CAPT  = 3'd4,
      ST_EMIT  = 3'd5,
      ST_FIN   = 3'd6
   } coll_state_t;

   // True when a move lane carries no move
   function automatic logic mv_is_invalid(input logic [MVW-1:0] mv);
      return mv[FLG_INVALID];
   endfunction

   // Saturating increment for the move counter
   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      logic [CNTW-1:0] r;
      if (v == {CNTW{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(CNTW-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   // One-hot read request for a square index
   function automatic logic [NSQ-1:0] sq_onehot(input logic [SQW-1:0] s);
      logic [NSQ-1:0] v;
      v    = {NSQ{1'b0}};
      v[s] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/move_lane_sel.sv
// Combinational 8:1 move-lane mux over a 152-bit move word, plus the
// invalid flag of the selected lane. Lane k occupies bits [19k+18:19k].
module move_lane_sel
   import chess_pkg::*;
(
   input  logic [PAYW-1:0] i_word,
   input  logic [KW-1:0]   i_k,
   output logic [MVW-1:0]  o_lane,
   output logic            o_invalid
);

   // Select lane k and expose its invalid flag
   always_comb begin
      o_lane = {MVW{1'b0}};
      case (i_k)
         3'd0:    o_lane = i_word[0*MVW +: MVW];
         3'd1:    o_lane = i_word[1*MVW +: MVW];
         3'd2:    o_lane = i_word[2*MVW +: MVW];
         3'd3:    o_lane = i_word[3*MVW +: MVW];
         3'd4:    o_lane = i_word[4*MVW +: MVW];
         3'd5:    o_lane = i_word[5*MVW +: MVW];
         3'd6:    o_lane = i_word[6*MVW +: MVW];
         3'd7:    o_lane = i_word[7*MVW +: MVW];
         default: o_lane = {MVW{1'b0}};
      endcase
      o_invalid = mv_is_invalid(o_lane);
   end

endmodule

// File: rtl/move_collector.sv
// Drains the 64 per-square move FIFOs once every square reports done and
// serialises the valid moves of each FIFO word (lane 7 first) onto a single
// ready/valid stream, counting the moves emitted during the pass.
module move_collector
   import chess_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [NSQ-1:0]   i_sq_done,
   input  logic [NSQ-1:0]   i_sq_empty,
   input  logic [WORDW-1:0] i_sq_data,
   output logic [SQW-1:0]   o_sq_sel,
   output logic [NSQ-1:0]   o_sq_rden,
   output logic             o_mv_valid,
   input  logic             i_mv_ready,
   output logic [MVW-1:0]   o_mv_data,
   output logic [CNTW-1:0]  o_mv_count,
   output logic             o_overflow,
   output logic             o_busy,
   output logic             o_done
);

   coll_state_t     r_state;
   logic [SQW-1:0]  r_ptr;
   logic [NSQ-1:0]  r_rden;
   logic [PAYW-1:0] r_word;
   logic [KW-1:0]   r_k;
   logic            r_mv_valid;
   logic [MVW-1:0]  r_mv_data;
   logic [CNTW-1:0] r_cnt;
   logic            r_ovf;
   logic            r_busy;
   logic            r_done;

   logic [PAYW-1:0] w_src;
   logic [KW-1:0]   w_idx;
   logic [MVW-1:0]  w_lane;
   logic            w_inv;
   logic            w_all_done;
   logic            w_cur_empty;
   logic            w_hs;
   logic            w_adv;
   logic            w_last_lane;
   logic            w_unused;

   // The top byte of the FIFO word carries no lanes
   assign w_unused    = ^i_sq_data[WORDW-1:PAYW];

   assign w_all_done  = &i_sq_done;
   assign w_cur_empty = i_sq_empty[r_ptr];
   assign w_hs        = r_mv_valid & i_mv_ready;
   // Current lane is finished: either it was invalid (skip) or it was accepted
   assign w_adv       = (~r_mv_valid) | i_mv_ready;
   assign w_last_lane = (r_k == 3'd0);

   // Lane mux source: in CAPT look ahead at lane 7 of the incoming word,
   // in EMIT look at the next lane down of the stored word
   always_comb begin
      if (r_state == ST_CAPT) begin
         w_src = i_sq_data[PAYW-1:0];
         w_idx = 3'd7;
      end else begin
         w_src = r_word;
         w_idx = r_k - 3'd1;
      end
   end

   move_lane_sel u_lane_sel (
      .i_word    (w_src),
      .i_k       (w_idx),
      .o_lane    (w_lane),
      .o_invalid (w_inv)
   );

   // Collector FSM with all outputs registered
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= ST_IDLE;
         r_ptr      <= {SQW{1'b0}};
         r_rden     <= {NSQ{1'b0}};
         r_word     <= {PAYW{1'b0}};
         r_k        <= {KW{1'b0}};
         r_mv_valid <= 1'b0;
         r_mv_data  <= {MVW{1'b0}};
         r_cnt      <= {CNTW{1'b0}};
         r_ovf      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state <= ST_WAITD;
                  r_ptr   <= {SQW{1'b0}};
                  r_cnt   <= {CNTW{1'b0}};
                  r_ovf   <= 1'b0;
                  r_done  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            ST_WAITD: begin
               if (w_all_done) begin
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (!w_cur_empty) begin
                  r_state <= ST_READ;
                  r_rden  <= sq_onehot(r_ptr);
               end else if (r_ptr == 6'd63) begin
                  r_state <= ST_FIN;
               end else begin
                  r_ptr   <= r_ptr + 6'd1;
               end
            end
            ST_READ: begin
               // Read request lasts exactly the READ cycle
               r_rden  <= {NSQ{1'b0}};
               r_state <= ST_CAPT;
            end
            ST_CAPT: begin
               // Non-showahead FIFO: the word is on sq_data now
               r_word     <= i_sq_data[PAYW-1:0];
               r_k        <= 3'd7;
               r_mv_valid <= ~w_inv;
               if (!w_inv) begin
                  r_mv_data <= w_lane;
               end
               r_state    <= ST_EMIT;
            end
            ST_EMIT: begin
               if (w_hs) begin
                  r_cnt <= sat_inc(r_cnt);
                  if (r_cnt == {CNTW{1'b1}}) begin
                     r_ovf <= 1'b1;
                  end
               end
               if (w_adv) begin
                  if (w_last_lane) begin
                     // Same square again: it may hold further words
                     r_mv_valid <= 1'b0;
                     r_state    <= ST_SCAN;
                  end else begin
                     r_k        <= r_k - 3'd1;
                     r_mv_valid <= ~w_inv;
                     if (!w_inv) begin
                        r_mv_data <= w_lane;
                     end
                  end
               end
            end
            ST_FIN: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_rden     <= {NSQ{1'b0}};
               r_mv_valid <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign o_sq_sel   = r_ptr;
   assign o_sq_rden  = r_rden;
   assign o_mv_valid = r_mv_valid;
   assign o_mv_data  = r_mv_data;
   assign o_mv_count = r_cnt;
   assign o_overflow = r_ovf;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule

// File: tb/tb_move_collector.sv
// Self-checking bench for move_collector: FIFO model per square, randomized
// words and consumer backpressure, reference stream computed from the queued
// words in square/word/lane order.
module tb_move_collector;

   localparam int NSQ = 64;
   localparam logic [18:0] IMOV = 19'h40000;
   typedef logic [159:0] word_t;

   logic          clk;
   logic          reset;
   logic          start;
   logic [63:0]   sq_done;
   logic [63:0]   sq_empty;
   logic [159:0]  sq_data;
   logic [5:0]    sq_sel;
   logic [63:0]   sq_rden;
   logic          mv_valid;
   logic          mv_ready;
   logic [18:0]   mv_data;
   logic [7:0]    mv_count;
   logic          overflow;
   logic          busy;
   logic          done;

   word_t         fq [NSQ][$];
   logic [18:0]   got_mv[$];
   logic [18:0]   exp_mv[$];
   int            got_rd[$];
   int            exp_rd[$];

   int            n_chk;
   int            n_pass;
   int            bad_rd;
   int            bad_hold;
   int            n_stall;
   int            first_rd;
   int            tick_no;
   int            bp_mode;
   int            bp_left;
   bit            bp_used;
   bit            pend_valid;
   word_t         pend_word;
   bit            prev_stall;
   logic [18:0]   prev_data;

   move_collector dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_start    (start),
      .i_sq_done  (sq_done),
      .i_sq_empty (sq_empty),
      .i_sq_data  (sq_data),
      .o_sq_sel   (sq_sel),
      .o_sq_rden  (sq_rden),
      .o_mv_valid (mv_valid),
      .i_mv_ready (mv_ready),
      .o_mv_data  (mv_data),
      .o_mv_count (mv_count),
      .o_overflow (overflow),
      .o_busy     (busy),
      .o_done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic refresh_empty();
      for (int s = 0; s < NSQ; s++) sq_empty[s] = (fq[s].size() == 0);
   endtask

   task automatic clear_fifos();
      for (int s = 0; s < NSQ; s++) fq[s].delete();
      refresh_empty();
   endtask

   function automatic word_t rnd_word(input int p_valid);
      word_t w;
      logic [18:0] ln;
      w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      for (int k = 0; k < 8; k++) begin
         ln = 19'($urandom()) & 19'h3FFFF;
         if ($urandom_range(0, 99) >= p_valid) ln = ln | IMOV;
         w[19*k +: 19] = ln;
      end
      return w;
   endfunction

   // One clock: FIFO model, stream observation, next mv_ready
   task automatic tick();
      @(negedge clk);
      tick_no++;
      if (pend_valid) begin
         sq_data    = pend_word;
         pend_valid = 1'b0;
      end else begin
         sq_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (prev_stall && (!mv_valid || mv_data !== prev_data)) bad_hold++;
      if (sq_rden != 64'd0) begin
         if (first_rd < 0) first_rd = tick_no;
         if ($countones(sq_rden) != 1 || !sq_rden[sq_sel]) bad_rd++;
         got_rd.push_back(int'(sq_sel));
         if (fq[sq_sel].size() > 0) begin
            pend_word  = fq[sq_sel].pop_front();
            pend_valid = 1'b1;
         end else begin
            bad_rd++;
         end
      end
      case (bp_mode)
         0: mv_ready = 1'b1;
         1: mv_ready = ($urandom_range(0, 3) != 0);
         default: begin
            if (mv_valid && !bp_used) begin
               bp_used = 1'b1;
               bp_left = 5;
            end
            mv_ready = (bp_left == 0);
            if (bp_left > 0) bp_left--;
         end
      endcase
      if (mv_valid && mv_ready) got_mv.push_back(mv_data);
      if (mv_valid && !mv_ready) n_stall++;
      prev_stall = mv_valid && !mv_ready;
      prev_data  = mv_data;
      refresh_empty();
   endtask

   task automatic reset_obs();
      got_mv.delete();
      got_rd.delete();
      bad_rd     = 0;
      bad_hold   = 0;
      n_stall    = 0;
      first_rd   = -1;
      tick_no    = 0;
      bp_used    = 1'b0;
      bp_left    = 0;
      prev_stall = 1'b0;
   endtask

   // Full pass: reference stream from queued words, then start and compare
   task automatic run_pass(input string tag, input int d_hold, input bit mid_start);
      int nw;
      int nerr;
      int exit_edge;
      int exp_done;
      int budget;
      int exp_cnt;
      word_t w;
      logic [18:0] ln;
      exp_mv.delete();
      exp_rd.delete();
      nw = 0;
      for (int s = 0; s < NSQ; s++) begin
         for (int i = 0; i < fq[s].size(); i++) begin
            nw++;
            exp_rd.push_back(s);
            w = fq[s][i];
            for (int k = 7; k >= 0; k--) begin
               ln = w[19*k +: 19];
               if (!ln[18]) exp_mv.push_back(ln);
            end
         end
      end
      reset_obs();
      sq_done = '1;
      if (d_hold > 0) sq_done[40] = 1'b0;
      refresh_empty();
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_on"}, 32'(busy), 32'd1);
      check({tag, "_done_clr"}, 32'(done), 32'd0);
      budget = 200 + d_hold + 11 * nw + 8 * exp_mv.size();
      while (!done && tick_no < budget) begin
         if (tick_no == d_hold) sq_done[40] = 1'b1;
         start = (mid_start && tick_no == 10);
         tick();
         start = 1'b0;
      end
      exit_edge = (d_hold + 1 > 2) ? d_hold + 1 : 2;
      exp_done  = exit_edge + 65 + 11 * nw + n_stall;
      exp_cnt   = (exp_mv.size() > 255) ? 255 : exp_mv.size();
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_done_cycle"}, 32'(tick_no), 32'(exp_done));
      check({tag, "_busy_off"}, 32'(busy), 32'd0);
      check({tag, "_nmoves"}, 32'(got_mv.size()), 32'(exp_mv.size()));
      nerr = 0;
      for (int i = 0; i < exp_mv.size() && i < got_mv.size(); i++)
         if (got_mv[i] !== exp_mv[i]) nerr++;
      check({tag, "_move_seq"}, 32'(nerr), 32'd0);
      check({tag, "_nreads"}, 32'(got_rd.size()), 32'(exp_rd.size()));
      nerr = 0;
      for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
         if (got_rd[i] != exp_rd[i]) nerr++;
      check({tag, "_read_seq"}, 32'(nerr), 32'd0);
      check({tag, "_bad_read"}, 32'(bad_rd), 32'd0);
      check({tag, "_hold"}, 32'(bad_hold), 32'd0);
      check({tag, "_count"}, 32'(mv_count), 32'(exp_cnt));
      check({tag, "_overflow"}, 32'(overflow), 32'(exp_mv.size() > 255));
      if (nw > 0) check({tag, "_first_read"}, 32'(first_rd), 32'(exit_edge + 1 + exp_rd[0]));
   endtask

   initial begin
      word_t w;
      int nrd;
      int n;
      int r;
      n_chk      = 0;
      n_pass     = 0;
      reset      = 1'b0;
      start      = 1'b0;
      sq_done    = '1;
      sq_data    = '0;
      mv_ready   = 1'b1;
      bp_mode    = 0;
      pend_valid = 1'b0;
      clear_fifos();
      reset_obs();
      repeat (2) @(negedge clk);
      check("rst_sq_sel", 32'(sq_sel), 32'd0);
      check("rst_rden", 32'(sq_rden != 64'd0), 32'd0);
      check("rst_mv_valid", 32'(mv_valid), 32'd0);
      check("rst_mv_data", 32'(mv_data), 32'd0);
      check("rst_count", 32'(mv_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // All FIFOs empty
      run_pass("empty", 0, 1'b0);

      // Square 12: lanes 7 and 3 valid
      clear_fifos();
      w = '0;
      w[159:152] = 8'hA5;
      for (int k = 0; k < 8; k++) w[19*k +: 19] = IMOV;
      w[19*7 +: 19] = 19'h0C1CE;
      w[19*3 +: 19] = 19'h01058;
      fq[12].push_back(w);
      run_pass("sq12", 0, 1'b0);
      if (got_mv.size() >= 2) begin
         check("sq12_mv0", 32'(got_mv[0]), 32'h0C1CE);
         check("sq12_mv1", 32'(got_mv[1]), 32'h01058);
      end

      // Square 0 twice, square 63 once, all lanes valid
      clear_fifos();
      fq[0].push_back(rnd_word(100));
      fq[0].push_back(rnd_word(100));
      fq[63].push_back(rnd_word(100));
      run_pass("sq0_63", 0, 1'b0);

      // Five-cycle backpressure on the first valid lane
      clear_fifos();
      fq[5].push_back(rnd_word(100));
      bp_mode = 2;
      run_pass("bp5", 0, 1'b0);
      check("bp5_stalls", 32'(n_stall), 32'd5);
      bp_mode = 0;

      // sq_done[40] held low for 20 cycles
      clear_fifos();
      fq[0].push_back(rnd_word(60));
      run_pass("done40", 20, 1'b0);

      // Randomized boards with random backpressure
      bp_mode = 1;
      for (int p = 0; p < 4; p++) begin
         clear_fifos();
         for (int s = 0; s < NSQ; s++) begin
            r = $urandom_range(0, 9);
            n = (r < 6) ? 0 : ((r < 9) ? 1 : 2);
            for (int i = 0; i < n; i++) fq[s].push_back(rnd_word($urandom_range(0, 100)));
         end
         run_pass($sformatf("rnd%0d", p), 0, (p == 1));
      end

      // Counter saturation and overflow
      bp_mode = 0;
      clear_fifos();
      for (int s = 0; s < 36; s++) fq[s].push_back(rnd_word(100));
      run_pass("ovf", 0, 1'b0);

      // Reset during EMIT, then a clean pass over what is left
      bp_mode = 1;
      clear_fifos();
      fq[3].push_back(rnd_word(100));
      fq[9].push_back(rnd_word(80));
      fq[50].push_back(rnd_word(80));
      reset_obs();
      sq_done = '1;
      refresh_empty();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!mv_valid && n < 300) begin
         tick();
         n++;
      end
      check("rst_reach_emit", 32'(mv_valid), 32'd1);
      reset = 1'b0;
      #1;
      check("arst_sq_sel", 32'(sq_sel), 32'd0);
      check("arst_rden", 32'(sq_rden != 64'd0), 32'd0);
      check("arst_mv_valid", 32'(mv_valid), 32'd0);
      check("arst_mv_data", 32'(mv_data), 32'd0);
      check("arst_count", 32'(mv_count), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      pend_valid = 1'b0;
      prev_stall = 1'b0;
      nrd = got_rd.size();
      repeat (3) tick();
      check("arst_no_read", 32'(got_rd.size()), 32'(nrd));
      reset = 1'b1;
      run_pass("post_rst", 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
